// File: rtl/analog_pkg.sv
// Shared analog-path definitions for the sine stage and its pin driver.
package analog_pkg;

  localparam int ANALOG_W  = 6;   // sine stage output width
  localparam int DIGITAL_W = 12;

  typedef logic [ANALOG_W-1:0] analog_t;

endpackage

// File: rtl/analog_pwm_out_if.sv
// Sample stream handshake into the PWM pin driver.
interface analog_pwm_out_if #(
  parameter int DATA_W = analog_pkg::ANALOG_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/analog_sample_fifo.sv
// Small synchronous sample FIFO; full/empty derive from an occupancy count.
module analog_sample_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointer/occupancy update; simultaneous push+pop leaves count unchanged.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/analog_pwm_out.sv
// PWM pin driver: buffers samples and replays each as one 2**DATA_W-tick frame.
// Optional: ANALOG_PWM_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module analog_pwm_out
  import analog_pkg::*;
#(
  parameter int DATA_W     = ANALOG_W,
  parameter int PRESCALE   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  analog_pwm_out_if.slave   s,
  output logic              pwm_out,
  output logic              frame_start,
`ifdef ANALOG_PWM_UNDERRUN_CNT_EN
  output logic              underrun,
  output logic [15:0]       underrun_cnt
`else
  output logic              underrun
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [DATA_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;
  logic              tick, load;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign s.s_ready   = !fifo_full;
  assign fifo_push   = s.s_valid && !fifo_full;
  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  analog_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (s.s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Prescaler, frame counter, duty load and pin compare.
  always_comb begin
    tick      = enable && (pre_cnt_q == PRE_MAX);
    pre_cnt_d = '0;
    frm_cnt_d = '0;
    if (enable) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      frm_cnt_d = tick ? frm_cnt_q + 1'b1 : frm_cnt_q;
    end
    load          = enable && (frm_cnt_q == '0) && (pre_cnt_q == '0);
    fifo_pop      = load && !fifo_empty;
    duty_d        = fifo_pop ? fifo_rdata : duty_q;
    frame_start_d = load;
    underrun_d    = load && fifo_empty;
    // Compare against the duty being loaded so count 0 of a frame already
    // uses that frame's own duty; this gives exactly duty ticks high per frame.
    pwm_d         = enable && (frm_cnt_q < duty_d);
  end

  // Driver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      frm_cnt_q     <= '0;
      duty_q        <= '0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      frm_cnt_q     <= frm_cnt_d;
      duty_q        <= duty_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

`ifdef ANALOG_PWM_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  assign underrun_cnt = ucnt_q;

  // Saturating count of underrun pulses.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_q && (ucnt_q != '1)) ucnt_d = ucnt_q + 1'b1;
  end

  // Underrun counter register; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end
`endif

endmodule

// File: tb/tb_analog_pwm_out.sv
// Directed scoreboard bench for analog_pwm_out (PRESCALE=1 and PRESCALE=3 instances).
module tb_analog_pwm_out;

  typedef struct packed {
    logic [31:0] hi;
    logic        und;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic enable3 = 1'b0;
  logic pwm_out, frame_start, underrun;
  logic pwm3, fs3, un3;
`ifdef ANALOG_PWM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt, ucnt3;
`endif

  int   checks = 0;
  int   errors = 0;
  int   und_seen = 0;
  exp_t sb[$];

  analog_pwm_out_if #(.DATA_W(6)) bus  ();
  analog_pwm_out_if #(.DATA_W(6)) bus3 ();

  always #5 clk = ~clk;

  analog_pwm_out #(.DATA_W(6), .PRESCALE(1), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .s           (bus.slave),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
`ifdef ANALOG_PWM_UNDERRUN_CNT_EN
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
`else
    .underrun    (underrun)
`endif
  );

  analog_pwm_out #(.DATA_W(6), .PRESCALE(3), .FIFO_DEPTH(4)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable3),
    .s           (bus3.slave),
    .pwm_out     (pwm3),
    .frame_start (fs3),
`ifdef ANALOG_PWM_UNDERRUN_CNT_EN
    .underrun    (un3),
    .underrun_cnt(ucnt3)
`else
    .underrun    (un3)
`endif
  );

  always @(negedge clk) if (rst_n && underrun === 1'b1) und_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] d);
    int w = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (bus.s_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", bus.s_ready, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic measure();
    exp_t e;
    int   hi = 0;
    int   w = 0;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
      return;
    end
    e = sb.pop_front();
    while (frame_start !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("frame_start_seen", frame_start, 1);
    chk("underrun_at_start", underrun, e.und);
    for (int i = 0; i < 64; i++) begin
      if (pwm_out === 1'b1) hi++;
      @(negedge clk);
    end
    chk("high_clks", hi, e.hi);
    chk("frame_len", frame_start, 1);
  endtask

  initial begin
    logic [5:0] vals [6];
    int idx, hi, w;
    logic acc;
    vals = '{6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10};
    bus.s_valid = 1'b0;  bus.s_data = '0;
    bus3.s_valid = 1'b0; bus3.s_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", bus.s_ready, 1);

    // 1: enabled with no samples -> underrun every frame, pin low
    rst_n = 1'b1;
    enable = 1'b1;
    sb.push_back('{hi: 0, und: 1'b1});
    sb.push_back('{hi: 0, und: 1'b1});
    measure(); measure();

    // 2: push 16 while idle, then enable
    enable = 1'b0;
    push(6'd16);
    enable = 1'b1;
    @(negedge clk);
    chk("lat_frame_start", frame_start, 1);
    chk("lat_pwm", pwm_out, 1);
    sb.push_back('{hi: 16, und: 1'b0});
    sb.push_back('{hi: 16, und: 1'b1});
    sb.push_back('{hi: 16, und: 1'b1});
    measure(); measure(); measure();

    // 3: back-to-back 0, 63, 32
    push(6'd0); push(6'd63); push(6'd32);
    sb.push_back('{hi: 0,  und: 1'b0});
    sb.push_back('{hi: 63, und: 1'b0});
    sb.push_back('{hi: 32, und: 1'b0});
    sb.push_back('{hi: 32, und: 1'b1});
    measure(); measure(); measure(); measure();

    // 4: hold s_valid for 6 samples with enable low
    enable = 1'b0;
    idx = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = vals[0];
    repeat (8) begin
      acc = bus.s_ready;
      @(negedge clk);
      if (acc === 1'b1) begin
        idx++;
        bus.s_data = vals[idx];
      end
    end
    chk("full_accepted", idx, 4);
    chk("full_ready", bus.s_ready, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("pop_frame_start", frame_start, 1);
    chk("ready_after_pop", bus.s_ready, 1);
    chk("pop_pwm", pwm_out, 1);
    @(negedge clk);
    chk("refull_ready", bus.s_ready, 0);
    bus.s_valid = 1'b0;
    sb.push_back('{hi: 6, und: 1'b0});
    sb.push_back('{hi: 7, und: 1'b0});
    sb.push_back('{hi: 8, und: 1'b0});
    sb.push_back('{hi: 9, und: 1'b0});
    sb.push_back('{hi: 9, und: 1'b1});
    measure(); measure(); measure(); measure(); measure();

    // 6: drop enable at clk 20 of a 40-duty frame, then re-enable
    push(6'd40);
    w = 0;
    while (frame_start !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("d40_start", frame_start, 1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out === 1'b1) hi++;
      @(negedge clk);
    end
    chk("d40_first20", hi, 20);
    chk("d40_pwm_before_drop", pwm_out, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_pwm", pwm_out, 0);
    repeat (3) @(negedge clk);
    chk("idle_pwm", pwm_out, 0);
    chk("idle_frame_start", frame_start, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_underrun", underrun, 1);
    chk("reen_pwm", pwm_out, 1);
    sb.push_back('{hi: 40, und: 1'b1});
    measure();
    enable = 1'b0;
    repeat (3) @(negedge clk);
`ifdef ANALOG_PWM_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, und_seen);
`endif

    // Async reset mid-frame discards FIFO contents and duty
    push(6'd20); push(6'd21);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_pwm", pwm_out, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_out, 0);
    chk("async_rst_ready", bus.s_ready, 1);
`ifdef ANALOG_PWM_UNDERRUN_CNT_EN
    chk("async_rst_ucnt", underrun_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_underrun", underrun, 1);
    chk("post_rst_pwm", pwm_out, 0);
    enable = 1'b0;

    // 5: PRESCALE=3, duty 10 -> 30 high clks of 192
    bus3.s_valid = 1'b1;
    bus3.s_data  = 6'd10;
    @(negedge clk);
    bus3.s_valid = 1'b0;
    enable3 = 1'b1;
    w = 0;
    while (fs3 !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("p3_start", fs3, 1);
    chk("p3_underrun", un3, 0);
    hi = 0;
    for (int i = 0; i < 192; i++) begin
      if (pwm3 === 1'b1) hi++;
      @(negedge clk);
    end
    chk("p3_high", hi, 30);
    chk("p3_frame_len", fs3, 1);
    chk("p3_next_underrun", un3, 1);
    enable3 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
